// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_reg_if #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;

  // Environment view: produces upstream entries and downstream ready.
  modport master (
    output in_valid, in_ctrl, in_data, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_pc
  );

  // Stage view.
  modport slave (
    input  in_valid, in_ctrl, in_data, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_pc
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional skid entry, hazard bubbles,
// flush kill and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SKID   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             hazard_detected,
  input  logic             clear_counts,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  logic out_valid, skid_valid, in_ready, accept, drain, bubble_inc, stall_inc;

  assign out_valid  = (state_q != S_EMPTY);
  assign skid_valid = (state_q == S_SKID);

  always_comb begin
    if (SKID != 0) in_ready = !skid_valid && !hazard_detected && !flush;
    else           in_ready = (!out_valid || bus.out_ready) && !hazard_detected && !flush;
  end

  assign accept    = bus.in_valid && in_ready;
  assign drain     = out_valid && bus.out_ready;
  assign stall_inc = out_valid && !bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    bubble_inc  = 1'b0;
    if (flush) begin
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      main_pc_d   = bus.in_pc;
    end else if (hazard_detected) begin
      // A bubble only overwrites main when its current occupant is leaving.
      if (state_q == S_EMPTY || (state_q == S_FULL && drain)) begin
        state_d     = S_EMPTY;
        main_ctrl_d = '0;
        main_data_d = '0;
        main_pc_d   = bus.in_pc;
        bubble_inc  = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d     = S_FULL;
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
            main_pc_d   = bus.in_pc;
          end
        end
        S_FULL: begin
          if (drain && accept) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
            main_pc_d   = bus.in_pc;
          end else if (drain) begin
            state_d     = S_EMPTY;
            main_ctrl_d = '0;
          end else if (accept) begin
            state_d     = S_SKID;
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
            skid_pc_d   = bus.in_pc;
          end
        end
        S_SKID: begin
          if (drain) begin
            state_d     = S_FULL;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            main_pc_d   = skid_pc_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (clear_counts) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall_inc && stall_cnt_q != '1)   stall_cnt_d  = stall_cnt_q + 1'b1;
      if (bubble_inc && bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      main_pc_q    <= '0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      main_pc_q    <= main_pc_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_pc    = main_pc_q;
  assign stall_count   = stall_cnt_q;
  assign bubble_count  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: dut_a has the skid entry and 4-bit counters, dut_b is single-entry.
module tb_pipe_stage_reg;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush_a = 1'b0, hazard_a = 1'b0, clear_a = 1'b0;
  logic flush_b = 1'b0, hazard_b = 1'b0, clear_b = 1'b0;
  logic [3:0] stall_a, bubble_a, stall_b, bubble_b;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(32), .PC_W(32)) ifa ();
  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(32), .PC_W(32)) ifb ();

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .PC_W(32), .CNT_W(4), .SKID(1)) dut_a (
    .clock(clock), .reset(reset), .flush(flush_a), .hazard_detected(hazard_a),
    .clear_counts(clear_a), .bus(ifa), .stall_count(stall_a), .bubble_count(bubble_a));

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(32), .PC_W(32), .CNT_W(4), .SKID(0)) dut_b (
    .clock(clock), .reset(reset), .flush(flush_b), .hazard_detected(hazard_b),
    .clear_counts(clear_b), .bus(ifb), .stall_count(stall_b), .bubble_count(bubble_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] pc, input logic rdy);
    ifa.in_valid  = v;
    ifa.in_pc     = pc;
    ifa.in_ctrl   = pc[15:0];
    ifa.in_data   = pc + 32'h1000;
    ifa.out_ready = rdy;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] pc, input logic rdy);
    ifb.in_valid  = v;
    ifb.in_pc     = pc;
    ifb.in_ctrl   = pc[15:0];
    ifb.in_data   = pc + 32'h2000;
    ifb.out_ready = rdy;
  endtask

  initial begin
    drive_a(1'b0, 32'h0, 1'b0);
    drive_b(1'b0, 32'h0, 1'b0);
    #12 reset = 1'b0;
    #1;
    // Reset state
    chk("rst_a_valid", ifa.out_valid, 0);
    chk("rst_a_ctrl",  ifa.out_ctrl, 0);
    chk("rst_a_pc",    ifa.out_pc, 0);
    chk("rst_a_stall", stall_a, 0);
    chk("rst_a_bub",   bubble_a, 0);
    chk("rst_a_ready", ifa.in_ready, 1);
    chk("rst_b_valid", ifb.out_valid, 0);
    chk("rst_b_ready", ifb.in_ready, 1);

    // Streaming, 1-cycle latency
    drive_a(1'b1, 32'h00, 1'b1); tick;
    chk("s0_pc", ifa.out_pc, 32'h00); chk("s0_valid", ifa.out_valid, 1);
    drive_a(1'b1, 32'h04, 1'b1); tick;
    chk("s1_pc", ifa.out_pc, 32'h04); chk("s1_ctrl", ifa.out_ctrl, 16'h04);
    drive_a(1'b1, 32'h08, 1'b1); tick;
    chk("s2_pc", ifa.out_pc, 32'h08); chk("s2_data", ifa.out_data, 32'h1008);
    chk("s2_valid", ifa.out_valid, 1);
    chk("s_stall", stall_a, 0); chk("s_bub", bubble_a, 0);
    drive_a(1'b0, 32'h0C, 1'b1); tick;
    chk("s_empty_valid", ifa.out_valid, 0); chk("s_empty_ctrl", ifa.out_ctrl, 0);

    // Backpressure into the skid entry
    drive_a(1'b1, 32'h10, 1'b1); tick;
    chk("bp_full_pc", ifa.out_pc, 32'h10);
    drive_a(1'b1, 32'h14, 1'b0); tick;
    chk("bp_skid_ready", ifa.in_ready, 0);
    chk("bp_skid_pc", ifa.out_pc, 32'h10);
    tick; tick;
    chk("bp_stall3", stall_a, 3);
    chk("bp_hold_pc", ifa.out_pc, 32'h10); chk("bp_hold_valid", ifa.out_valid, 1);
    drive_a(1'b0, 32'h18, 1'b1); tick;
    chk("bp_promote_pc", ifa.out_pc, 32'h14); chk("bp_promote_ctrl", ifa.out_ctrl, 16'h14);
    chk("bp_promote_ready", ifa.in_ready, 1); chk("bp_stall_keep", stall_a, 3);
    tick;
    chk("bp_drained", ifa.out_valid, 0);

    // Hazard bubble from EMPTY
    drive_a(1'b1, 32'h20, 1'b1);
    ifa.in_ctrl = 16'hFFFF;
    hazard_a = 1'b1; #1;
    chk("hz_ready", ifa.in_ready, 0);
    tick;
    chk("hz_valid", ifa.out_valid, 0); chk("hz_ctrl", ifa.out_ctrl, 0);
    chk("hz_data", ifa.out_data, 0);   chk("hz_pc", ifa.out_pc, 32'h20);
    chk("hz_bub", bubble_a, 1);
    hazard_a = 1'b0;
    drive_a(1'b1, 32'h24, 1'b0); tick;
    chk("hz_full_pc", ifa.out_pc, 32'h24);
    drive_a(1'b1, 32'h28, 1'b0); hazard_a = 1'b1; tick;
    chk("hz_hold_pc", ifa.out_pc, 32'h24); chk("hz_hold_valid", ifa.out_valid, 1);
    chk("hz_hold_bub", bubble_a, 1);       chk("hz_hold_stall", stall_a, 4);

    // Flush with hazard while in SKID
    hazard_a = 1'b0; tick;
    chk("fl_skid_ready", ifa.in_ready, 0);
    drive_a(1'b1, 32'h30, 1'b0); flush_a = 1'b1; hazard_a = 1'b1; tick;
    chk("fl_valid", ifa.out_valid, 0); chk("fl_ctrl", ifa.out_ctrl, 0);
    chk("fl_data", ifa.out_data, 0);   chk("fl_pc", ifa.out_pc, 32'h30);
    chk("fl_bub", bubble_a, 1);        chk("fl_stall", stall_a, 6);
    flush_a = 1'b0; hazard_a = 1'b0;
    drive_a(1'b1, 32'h34, 1'b1); #1;
    chk("fl_ready_after", ifa.in_ready, 1);
    tick;
    chk("fl_next_pc", ifa.out_pc, 32'h34); chk("fl_next_ctrl", ifa.out_ctrl, 16'h34);
    drive_a(1'b0, 32'h38, 1'b1); tick;
    chk("fl_skid_gone", ifa.out_valid, 0);

    // Counter saturation and clear
    drive_a(1'b1, 32'h40, 1'b1); tick;
    drive_a(1'b0, 32'h44, 1'b0);
    repeat (20) tick;
    chk("sat_stall", stall_a, 15);
    clear_a = 1'b1; tick;
    chk("clr_stall", stall_a, 0); chk("clr_bub", bubble_a, 0);
    clear_a = 1'b0; tick;
    chk("clr_restart", stall_a, 1);

    // Async reset while in SKID
    drive_a(1'b1, 32'h48, 1'b0); tick;
    chk("ar_skid_ready", ifa.in_ready, 0);
    drive_a(1'b0, 32'h4C, 1'b0);
    #2 reset = 1'b1; #1;
    chk("ar_valid", ifa.out_valid, 0); chk("ar_ctrl", ifa.out_ctrl, 0);
    chk("ar_pc", ifa.out_pc, 0);       chk("ar_data", ifa.out_data, 0);
    chk("ar_stall", stall_a, 0);       chk("ar_ready", ifa.in_ready, 1);
    reset = 1'b0;
    tick;
    chk("ar_still_empty", ifa.out_valid, 0);

    // Single-entry variant: combinational in_ready, no third entry
    drive_b(1'b1, 32'h50, 1'b1); tick;
    chk("b_full_pc", ifb.out_pc, 32'h50);
    ifb.in_pc = 32'h54; ifb.in_ctrl = 16'h54; ifb.out_ready = 1'b0; #1;
    chk("b_ready_low", ifb.in_ready, 0);
    ifb.out_ready = 1'b1; #1;
    chk("b_ready_high", ifb.in_ready, 1);
    ifb.out_ready = 1'b0; tick; tick;
    chk("b_hold_pc", ifb.out_pc, 32'h50); chk("b_hold_valid", ifb.out_valid, 1);
    chk("b_stall", stall_b, 2);
    ifb.out_ready = 1'b1; tick;
    chk("b_next_pc", ifb.out_pc, 32'h54);
    drive_b(1'b0, 32'h58, 1'b1); tick;
    chk("b_drained", ifb.out_valid, 0); chk("b_drained_ctrl", ifb.out_ctrl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
